// File: rtl/tnn_quant_pkg.sv
// rtl/tnn_quant_pkg.sv - shared constants, operand vector type and default thresholds for the feature quantizer
package tnn_quant_pkg;

    localparam int N_FEAT = 3;
    localparam int N_THR  = 7;
    localparam int Q_W    = 3;

    typedef struct packed {
        logic [Q_W-1:0] a;
        logic [Q_W-1:0] b;
        logic [Q_W-1:0] c;
    } opvec_t;

    // Evenly spaced thresholds at 1/8 .. 7/8 of the feature range.
    function automatic logic [31:0] default_thr(input int k, input int feat_w);
        return 32'((k + 1) << (feat_w - 3));
    endfunction

endpackage

// File: rtl/tnn_thermo_count.sv
// rtl/tnn_thermo_count.sv - counts how many of N_THR thresholds a value meets
module tnn_thermo_count
    import tnn_quant_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0]       value_i,
    input  logic [N_THR*W-1:0] thr_i,
    output logic [Q_W-1:0]     count_o
);

    always_comb begin
        count_o = '0;
        for (int k = 0; k < N_THR; k++) begin
            count_o = count_o + Q_W'(value_i >= thr_i[k*W +: W]);
        end
    end

endmodule

// File: rtl/tnn_feature_quantizer.sv
// rtl/tnn_feature_quantizer.sv - quantizes a serial feature stream into 3x3-bit operand vectors; TNN_QUANT_THR_LOAD_EN adds writable thresholds
module tnn_feature_quantizer
    import tnn_quant_pkg::*;
#(
    parameter int FEAT_W = 12,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FEAT_W-1:0] in_data,
    input  logic              in_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Q_W-1:0]    input_a,
    output logic [Q_W-1:0]    input_b,
    output logic [Q_W-1:0]    input_c,
    output logic [DROP_W-1:0] drop_cnt
`ifdef TNN_QUANT_THR_LOAD_EN
    ,
    input  logic              thr_we,
    input  logic [1:0]        thr_feat,
    input  logic [2:0]        thr_idx,
    input  logic [FEAT_W-1:0] thr_data
`endif
);

    logic [1:0]              idx_q, idx_d;
    logic [Q_W-1:0]          pa_q, pa_d, pb_q, pb_d;
    opvec_t                  vec_q, vec_d;
    logic                    out_valid_q, out_valid_d;
    logic [DROP_W-1:0]       drop_q, drop_d;
    logic [1:0]              pos;
    logic                    accept;
    logic [Q_W-1:0]          q;
    logic [N_THR*FEAT_W-1:0] thr_sel;

    assign in_ready = !(idx_q == 2'd2 && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign pos      = in_first ? 2'd0 : idx_q;

`ifdef TNN_QUANT_THR_LOAD_EN
    logic [FEAT_W-1:0] thr_q [N_FEAT][N_THR];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < N_FEAT; f++) begin
                for (int k = 0; k < N_THR; k++) begin
                    thr_q[f][k] <= FEAT_W'(default_thr(k, FEAT_W));
                end
            end
        end else if (thr_we && thr_feat < 2'(N_FEAT) && thr_idx < 3'(N_THR)) begin
            thr_q[thr_feat][thr_idx] <= thr_data;
        end
    end

    always_comb begin
        thr_sel = '0;
        for (int k = 0; k < N_THR; k++) begin
            thr_sel[k*FEAT_W +: FEAT_W] = thr_q[pos][k];
        end
    end
`else
    // All features share the same constant set, so pos does not affect the compare.
    always_comb begin
        thr_sel = '0;
        for (int k = 0; k < N_THR; k++) begin
            thr_sel[k*FEAT_W +: FEAT_W] = FEAT_W'(default_thr(k, FEAT_W));
        end
    end
`endif

    tnn_thermo_count #(.W(FEAT_W)) u_count (
        .value_i (in_data),
        .thr_i   (thr_sel),
        .count_o (q)
    );

    always_comb begin
        idx_d       = idx_q;
        pa_d        = pa_q;
        pb_d        = pb_q;
        vec_d       = vec_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            if (in_first && idx_q != 2'd0 && drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
            case (pos)
                2'd0: begin
                    pa_d  = q;
                    idx_d = 2'd1;
                end
                2'd1: begin
                    pb_d  = q;
                    idx_d = 2'd2;
                end
                default: begin
                    // A load in the same cycle as a consume keeps out_valid high.
                    vec_d       = {pa_q, pb_q, q};
                    out_valid_d = 1'b1;
                    idx_d       = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            pa_q        <= '0;
            pb_q        <= '0;
            vec_q       <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            idx_q       <= idx_d;
            pa_q        <= pa_d;
            pb_q        <= pb_d;
            vec_q       <= vec_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign input_a   = vec_q.a;
    assign input_b   = vec_q.b;
    assign input_c   = vec_q.c;
    assign drop_cnt  = drop_q;

endmodule
